// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-ramp slice: ramp FSM states,
// the PWM period and the default widths.
package pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_e;

   localparam int PWM_PERIOD     = 256;
   localparam int DUTY_W_DEFAULT = 8;
   localparam int HOLD_W_DEFAULT = 8;

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM period counter; frame_start marks the last cycle of each
// period so that the following edge is the period boundary.
module pwm_frame_timer #(
   parameter int W = 8
) (
   input  logic clk,
   input  logic rst,
   output logic frame_start
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign frame_start = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer stepping duty toward a requested target, one update per
// (hold+1) PWM periods, only on period boundaries. Optional PWM_RAMP_DONE_EN adds ramp_done.
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEFAULT,
   parameter int HOLD_W = HOLD_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tgt_valid,
   output logic              tgt_ready,
   input  logic [DUTY_W-1:0] tgt_duty,
   input  logic [DUTY_W-1:0] tgt_step,
   input  logic [HOLD_W-1:0] tgt_hold,
   output logic [DUTY_W-1:0] duty,
   output logic              frame_start,
`ifdef PWM_RAMP_DONE_EN
   output logic              ramp_done,
`endif
   output logic              busy
);

   ramp_state_e       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [DUTY_W-1:0] step_q, step_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [DUTY_W:0]   diff;
   logic [DUTY_W:0]   mag;
   logic [DUTY_W-1:0] next_duty;
`ifdef PWM_RAMP_DONE_EN
   logic              done_q, done_d;
`endif

   pwm_frame_timer #(
      .W (DUTY_W)
   ) u_frame_timer (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start)
   );

   // Sign bit of the widened difference tells direction; clamping to the
   // target when the remaining distance fits in one step prevents overshoot.
   always_comb begin
      diff = {1'b0, tgt_q} - {1'b0, duty_q};
      mag  = diff[DUTY_W] ? (~diff + 1'b1) : diff;
      if ((step_q == '0) || (mag <= {1'b0, step_q})) begin
         next_duty = tgt_q;
      end else if (diff[DUTY_W]) begin
         next_duty = duty_q - step_q;
      end else begin
         next_duty = duty_q + step_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      tgt_ready  = 1'b0;
      busy       = 1'b0;
`ifdef PWM_RAMP_DONE_EN
      done_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            tgt_ready = 1'b1;
            if (tgt_valid) begin
               tgt_d      = tgt_duty;
               step_d     = tgt_step;
               hold_d     = tgt_hold;
               hold_cnt_d = '0;
               if (tgt_duty == duty_q) begin
`ifdef PWM_RAMP_DONE_EN
                  done_d = 1'b1;
`endif
               end else begin
                  state_d = RAMP;
               end
            end
         end
         RAMP: begin
            busy = 1'b1;
            // frame_start high means this edge is the 255->0 boundary.
            if (frame_start) begin
               if (hold_cnt_q == hold_q) begin
                  duty_d     = next_duty;
                  hold_cnt_d = '0;
                  if (next_duty == tgt_q) begin
                     state_d = IDLE;
`ifdef PWM_RAMP_DONE_EN
                     done_d  = 1'b1;
`endif
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         tgt_q      <= '0;
         step_q     <= '0;
         hold_q     <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         tgt_q      <= tgt_d;
         step_q     <= step_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

`ifdef PWM_RAMP_DONE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign ramp_done = done_q;
`endif

   assign duty = duty_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed self-checking bench for pwm_duty_ramp; expected duties are
// hand-computed and period position comes from an independent phase model.
module tb_pwm_duty_ramp;

   logic       clk;
   logic       rst;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] tgt_duty;
   logic [7:0] tgt_step;
   logic [7:0] tgt_hold;
   logic [7:0] duty;
   logic       frame_start;
   logic       busy;
`ifdef PWM_RAMP_DONE_EN
   logic       ramp_done;
`endif

   int         compared_cnt;
   int         mismatched_cnt;
   int         anomaly_cnt;
   logic [7:0] phase;

   pwm_duty_ramp dut (
      .clk         (clk),
      .rst         (rst),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .tgt_duty    (tgt_duty),
      .tgt_step    (tgt_step),
      .tgt_hold    (tgt_hold),
      .duty        (duty),
      .frame_start (frame_start),
`ifdef PWM_RAMP_DONE_EN
      .ramp_done   (ramp_done),
`endif
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference period position: 0 after reset, +1 per rising edge.
   always @(posedge clk or posedge rst) begin
      if (rst) phase <= 8'd0;
      else     phase <= phase + 8'd1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared_cnt++;
      assert (observed === expected) else begin
         mismatched_cnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [7:0] s, input logic [7:0] h);
      tgt_valid = v;
      tgt_duty  = d;
      tgt_step  = s;
      tgt_hold  = h;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Runs to the sample just after the next boundary edge, flagging any duty
   // change, stray ramp_done or frame_start disagreement along the way.
   task automatic advanceToBoundary(input string tag);
      logic [7:0] held;
      int         n;
      held = duty;
      n    = 0;
      do begin
         stepCycle();
         n++;
         if (frame_start !== (phase == 8'd255)) anomaly_cnt++;
         if ((phase != 8'd0) && (duty !== held)) anomaly_cnt++;
`ifdef PWM_RAMP_DONE_EN
         if ((phase != 8'd0) && (ramp_done !== 1'b0)) anomaly_cnt++;
`endif
      end while ((phase != 8'd0) && (n < 300));
      if (phase != 8'd0) begin
         mismatched_cnt++;
         $display("[TB] FAIL %s: boundary not reached, observed phase %0d expected 0", tag, phase);
      end
   endtask

   initial begin
      int fs_count;
      int fs_first;
      int fs_second;
      int duty_bad;
      int fs_early;

      compared_cnt   = 0;
      mismatched_cnt = 0;
      anomaly_cnt    = 0;
      rst            = 1'b1;
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_duty", duty, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_frame_start", frame_start, 0);
`ifdef PWM_RAMP_DONE_EN
      checkOutput("reset_ramp_done", ramp_done, 0);
`endif
      rst = 1'b0;
      #1;
      checkOutput("reset_ready", tgt_ready, 1);

      // Idle 600 cycles
      fs_count  = 0;
      fs_first  = -1;
      fs_second = -1;
      duty_bad  = 0;
      for (int k = 1; k <= 600; k++) begin
         stepCycle();
         if (duty !== 8'd0) duty_bad++;
         if (frame_start === 1'b1) begin
            fs_count++;
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
      end
      checkOutput("idle_duty_zero", duty_bad, 0);
      checkOutput("idle_fs_count", fs_count, 2);
      checkOutput("idle_fs_first", fs_first, 255);
      checkOutput("idle_fs_second", fs_second, 511);
      checkOutput("idle_ready", tgt_ready, 1);
      checkOutput("idle_busy", busy, 0);

      // 0 -> 100, step 30, hold 0
      applyStimulus(1'b1, 8'd100, 8'd30, 8'd0);
      checkOutput("r1_ready_pre", tgt_ready, 1);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      checkOutput("r1_busy_accept", busy, 1);
      checkOutput("r1_ready_ramp", tgt_ready, 0);
      checkOutput("r1_duty_accept", duty, 0);
      advanceToBoundary("r1_b1");
      checkOutput("r1_duty_30", duty, 30);
      checkOutput("r1_busy_mid", busy, 1);
      advanceToBoundary("r1_b2");
      checkOutput("r1_duty_60", duty, 60);
      advanceToBoundary("r1_b3");
      checkOutput("r1_duty_90", duty, 90);
      checkOutput("r1_busy_90", busy, 1);
      advanceToBoundary("r1_b4");
      checkOutput("r1_duty_100", duty, 100);
      checkOutput("r1_busy_end", busy, 0);
`ifdef PWM_RAMP_DONE_EN
      checkOutput("r1_done_pulse", ramp_done, 1);
`endif
      stepCycle();
`ifdef PWM_RAMP_DONE_EN
      checkOutput("r1_done_clear", ramp_done, 0);
`endif
      checkOutput("r1_anomalies", anomaly_cnt, 0);

      // 100 -> 20, step 0 jump
      applyStimulus(1'b1, 8'd20, 8'd0, 8'd0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      advanceToBoundary("r2_b1");
      checkOutput("r2_duty_20", duty, 20);
      checkOutput("r2_busy_end", busy, 0);
      stepCycle();

      // 20 -> 10, step 4, hold 2: update every third boundary
      applyStimulus(1'b1, 8'd10, 8'd4, 8'd2);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      advanceToBoundary("r3_b1");
      checkOutput("r3_hold_b1", duty, 20);
      advanceToBoundary("r3_b2");
      checkOutput("r3_hold_b2", duty, 20);
      advanceToBoundary("r3_b3");
      checkOutput("r3_duty_16", duty, 16);
      checkOutput("r3_busy_16", busy, 1);
      advanceToBoundary("r3_b4");
      advanceToBoundary("r3_b5");
      checkOutput("r3_hold_b5", duty, 16);
      advanceToBoundary("r3_b6");
      checkOutput("r3_duty_12", duty, 12);
      advanceToBoundary("r3_b7");
      advanceToBoundary("r3_b8");
      checkOutput("r3_busy_b8", busy, 1);
      advanceToBoundary("r3_b9");
      checkOutput("r3_duty_10", duty, 10);
      checkOutput("r3_busy_end", busy, 0);
      checkOutput("r3_anomalies", anomaly_cnt, 0);
      stepCycle();

      // 10 -> 255, step 0
      applyStimulus(1'b1, 8'd255, 8'd0, 8'd0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      advanceToBoundary("r4_b1");
      checkOutput("r4_duty_255", duty, 255);
      checkOutput("r4_busy_end", busy, 0);
      stepCycle();

      // 255 -> 200 with a request held high throughout the ramp
      applyStimulus(1'b1, 8'd200, 8'd30, 8'd0);
      stepCycle();
      applyStimulus(1'b1, 8'd50, 8'd0, 8'd0);
      checkOutput("r5_ready_ramp", tgt_ready, 0);
      advanceToBoundary("r5_b1");
      checkOutput("r5_duty_225", duty, 225);
      checkOutput("r5_ready_mid", tgt_ready, 0);
      advanceToBoundary("r5_b2");
      checkOutput("r5_duty_200", duty, 200);
      checkOutput("r5_ready_idle", tgt_ready, 1);
      checkOutput("r5_busy_idle", busy, 0);
      stepCycle();
      checkOutput("r5_held_accepted", busy, 1);
      checkOutput("r5_ready_after", tgt_ready, 0);
`ifdef PWM_RAMP_DONE_EN
      checkOutput("r5_done_single", ramp_done, 0);
`endif
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      advanceToBoundary("r5_b3");
      checkOutput("r5_duty_50", duty, 50);
      checkOutput("r5_busy_end", busy, 0);
      stepCycle();

      // Target equal to current duty: no RAMP entry
      applyStimulus(1'b1, 8'd50, 8'd7, 8'd0);
      checkOutput("eq_ready_pre", tgt_ready, 1);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      checkOutput("eq_busy", busy, 0);
      checkOutput("eq_ready", tgt_ready, 1);
`ifdef PWM_RAMP_DONE_EN
      checkOutput("eq_done_pulse", ramp_done, 1);
`endif
      stepCycle();
`ifdef PWM_RAMP_DONE_EN
      checkOutput("eq_done_clear", ramp_done, 0);
`endif
      advanceToBoundary("eq_b1");
      checkOutput("eq_duty_50", duty, 50);
      checkOutput("eq_busy_boundary", busy, 0);
      checkOutput("eq_anomalies", anomaly_cnt, 0);

      // Reset mid-ramp at duty 90
      applyStimulus(1'b1, 8'd200, 8'd40, 8'd0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 8'd0, 8'd0);
      advanceToBoundary("rs_b1");
      checkOutput("rs_duty_90", duty, 90);
      checkOutput("rs_busy_pre", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rs_async_duty", duty, 0);
      checkOutput("rs_async_busy", busy, 0);
      checkOutput("rs_async_frame_start", frame_start, 0);
`ifdef PWM_RAMP_DONE_EN
      checkOutput("rs_async_ramp_done", ramp_done, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rs_ready_release", tgt_ready, 1);
      fs_early = 0;
      for (int k = 1; k <= 254; k++) begin
         stepCycle();
         if (frame_start !== 1'b0) fs_early++;
      end
      checkOutput("rs_no_early_frame", fs_early, 0);
      stepCycle();
      checkOutput("rs_frame_at_255", frame_start, 1);
      checkOutput("rs_duty_after", duty, 0);
      checkOutput("rs_busy_after", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
      $finish;
   end

endmodule
